// File: rtl/mem_arbiter_if.sv
// Bundle of request, response and memory-side signals around mem_arbiter.
// The slave view belongs to the arbiter. The master view belongs to whatever
// surrounds it: the two requesting ports and the memory that returns mem_rdata.
interface mem_arbiter_if #(
  parameter int ADDR_SIZE = 16,
  parameter int WORD_SIZE = 16
);
  // instruction-fetch port
  logic                 if_req;
  logic [ADDR_SIZE-1:0] if_addr;
  logic [WORD_SIZE-1:0] if_rdata;
  logic                 if_ack;
  // data port
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ack;
  // memory side
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  // status
  logic                 busy;
  logic                 owner;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr,
           mem_wdata, busy, owner
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr,
           mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported memory with a
// fixed number of wait states. A grant captures the winning request, runs
// WAIT_STATES+1 access cycles, then pulses the owner's ack for one cycle.
// Ties are broken round-robin on the port that was served last.
module mem_arbiter #(
  parameter int ADDR_SIZE   = 16,
  parameter int WORD_SIZE   = 16,
  parameter int WAIT_STATES = 2
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 owner_reg;
  logic                 last_owner_reg;
  logic                 we_reg;
  logic [3:0]           cnt_reg;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [WORD_SIZE-1:0] wdata_reg;

  logic                 grant_valid;
  logic                 grant_port;
  logic                 last_cycle;

  // Pick the winner among the requests seen this cycle (0 = fetch, 1 = data).
  always_comb begin
    grant_valid = bus.if_req | bus.d_req;
    if (bus.if_req && bus.d_req) begin
      grant_port = ~last_owner_reg;
    end else begin
      grant_port = bus.d_req;
    end
  end

  assign last_cycle = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // State register plus the request capture, wait counter and fairness bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      we_reg         <= 1'b0;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            owner_reg <= grant_port;
            we_reg    <= grant_port & bus.d_we;
            addr_reg  <= grant_port ? bus.d_addr : bus.if_addr;
            wdata_reg <= grant_port ? bus.d_wdata : '0;
            cnt_reg   <= WS_INIT;
          end
        end
        ACCESS: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACK: begin
          last_owner_reg <= owner_reg;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state: requests only matter in IDLE; ACK always falls back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  if (cnt_reg == 4'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One read-data holding register per port (0 = fetch, 1 = data); a store
  // never overwrites the data port's last loaded word.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rdata
    logic [WORD_SIZE-1:0] rdata_reg;

    // Latch memory read data on the owner's final access cycle of a load.
    always_ff @(posedge clock) begin
      if (reset) begin
        rdata_reg <= '0;
      end else if (last_cycle && (owner_reg == 1'(gi)) && !we_reg) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  // Outputs decoded from state and the captured request registers only.
  always_comb begin
    bus.mem_en    = (state_reg == ACCESS);
    bus.mem_we    = last_cycle & we_reg;
    bus.mem_addr  = addr_reg;
    bus.mem_wdata = wdata_reg;
    bus.if_ack    = (state_reg == ACK) & ~owner_reg;
    bus.d_ack     = (state_reg == ACK) & owner_reg;
    bus.busy      = (state_reg != IDLE);
    bus.owner     = owner_reg;
    bus.if_rdata  = g_rdata[0].rdata_reg;
    bus.d_rdata   = g_rdata[1].rdata_reg;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, default 16, memory address width; WORD_SIZE, default 16, data width; WAIT_STATES, default 2, extra memory cycles per access (0..15).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request, level, held until if_ack
- if_addr  in  ADDR_SIZE  fetch address, stable while if_req high
- if_rdata  out  WORD_SIZE  fetched word, valid when if_ack high
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req high
- d_addr  in  ADDR_SIZE  data address, stable while d_req high
- d_wdata  in  WORD_SIZE  store data, stable while d_req high
- d_rdata  out  WORD_SIZE  loaded word, valid when d_ack high
- d_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data, valid on the last access cycle
- busy  out  1  high in any state other than IDLE
- owner  out  1  0 = fetch port granted, 1 = data port granted; meaningful only while mem_en is high

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and ACK, with one owner register and a 4-bit wait counter.
REQ-005 In IDLE, requests SHALL be sampled. If exactly one req is high, that port SHALL be granted. If both are high, the port not granted last SHALL be granted (round-robin on last_owner). Granting SHALL move the FSM to ACCESS with the counter loaded to WAIT_STATES.
REQ-006 At the grant edge, the granted port's address, we and wdata SHALL be captured into registers. The mem_* outputs SHALL be driven only from these registers.
REQ-007 In ACCESS, mem_en SHALL be 1 and the counter SHALL decrement each cycle. The last access cycle is the one with counter == 0, and it SHALL move the FSM to ACK.
REQ-008 mem_we SHALL be 1 only on the last ACCESS cycle, and only for a data store. This gives exactly one write per store. A fetch SHALL never write.
REQ-009 On the last ACCESS cycle, mem_rdata SHALL be registered into the owner's rdata output. A store SHALL leave d_rdata unchanged.
REQ-010 In ACK, the owner's ack SHALL be 1 for exactly one cycle, and mem_en SHALL be 0. The FSM SHALL return to IDLE unconditionally, and last_owner SHALL be updated.
REQ-011 Requests SHALL be ignored in ACCESS and ACK. A req still high in the first IDLE cycle after ACK SHALL be treated as a new request.
REQ-012 Latency SHALL be as follows. With a req sampled in IDLE at cycle N:
- mem_en is high for cycles N+1 .. N+1+WAIT_STATES;
- ack is high at cycle N+2+WAIT_STATES;
- the earliest next grant is at cycle N+3+WAIT_STATES.
REQ-013 With WAIT_STATES = 0, ACCESS SHALL last exactly 1 cycle, and ack SHALL occur 2 cycles after the sample.
REQ-014 if_ack and d_ack SHALL never be high in the same cycle. Ack SHALL go only to the owner.
REQ-015 If a req is deasserted mid-access, which is a protocol violation, the access SHALL complete and ack SHALL still pulse.
REQ-016 If no req is high in IDLE, the FSM SHALL remain in IDLE, with mem_en = 0 and mem_we = 0.

Reset
REQ-017 While reset is high, on the next posedge the FSM SHALL go to IDLE and the outputs SHALL be:
- if_ack = d_ack = 0;
- mem_en = mem_we = 0;
- busy = 0, owner = 0;
- mem_addr, mem_wdata, if_rdata and d_rdata = 0.
last_owner SHALL be set to 1, so that fetch wins the first tie.
REQ-018 Reset SHALL take precedence over every other event. A reset during ACCESS or ACK SHALL abort the access with no ack and no write. Requests present during reset SHALL be ignored, and they SHALL be sampled in the first cycle after reset deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios (WAIT_STATES = 2 unless stated):
- Single fetch: if_req=1, if_addr=0x0010, mem_rdata=0xBEEF on the last access cycle -> mem_en high for 3 cycles, if_ack at sample+4, if_rdata=0xBEEF, d_ack never high.
- Simultaneous requests out of reset: if_req=1 and d_req=1 (d_we=0, d_addr=0x0200) in the same cycle -> fetch granted first (owner=0), then data (owner=1) at the first IDLE after if_ack; two acks, never overlapping.
- Store: d_req=1, d_we=1, d_addr=0x0042, d_wdata=0x1234 -> mem_we high for exactly 1 cycle (the third mem_en cycle) with mem_addr=0x0042 and mem_wdata=0x1234; d_ack follows; d_rdata unchanged.
- Reset mid-access: assert reset during the second ACCESS cycle of a store -> no mem_we pulse, no d_ack, all outputs 0 on the next cycle; a held d_req is re-granted after reset drops.
- WAIT_STATES = 0, back-to-back fetches with if_req held high -> ack every 3 cycles, mem_en 1 cycle per access.
- Sustained contention: both reqs held high for 8 accesses -> owner alternates 0,1,0,1..., and neither port is granted twice in a row.
